// File: rtl/numeric_display_scanner_if.sv
// Bus bundle for numeric_display_scanner.
// The master drives the load request, the value and the decimal points.
// The slave returns busy, overflow and the multiplexed segment/anode drive.
interface numeric_display_scanner_if #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned BIN_W    = 14
);
    logic                load;
    logic [BIN_W-1:0]    value;
    logic [N_DIGITS-1:0] dp_sel;
    logic                busy;
    logic                overflow;
    logic [7:0]          seg_code;
    logic [N_DIGITS-1:0] anode;

    modport master (
        output load, value, dp_sel,
        input  busy, overflow, seg_code, anode
    );

    modport slave (
        input  load, value, dp_sel,
        output busy, overflow, seg_code, anode
    );
endinterface

// File: rtl/numeric_display_scanner.sv
// Multiplexed 7-segment numeric display driver.
// A captured binary value is converted to BCD by sequential shift-add-3
// (one bit per cycle), committed atomically to the display registers, and
// scanned out one digit per REFRESH_DIV cycles on active-low segments/anodes.
// Optional feature: define NUMERIC_DISPLAY_LZB_EN to compile in leading-zero
// blanking (digits above the most significant non-zero digit are dark).
module numeric_display_scanner #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                     clock,
    input  logic                     reset,
    numeric_display_scanner_if.slave bus
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned BIT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * N_DIGITS;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned OVF_LIMIT = pow10(N_DIGITS);

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t              state_q, state_d;

    // Conversion datapath
    logic [BIN_W-1:0]    sh_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    bcd_d;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [N_DIGITS-1:0] dp_cap_q;
    logic                ovf_cap_q;

    // Committed display contents
    logic [BCD_W-1:0]    disp_q;
    logic [N_DIGITS-1:0] dp_q;
    logic                ovf_q;

    // Scan and output registers
    logic [CNT_W-1:0]    refresh_q;
    logic [IDX_W-1:0]    scan_idx_q;
    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: load only honoured in IDLE, BIN_W conversion cycles, one commit cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.load) state_d = CONVERT;
            CONVERT: if (bit_cnt_q == BIT_W'(BIN_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One shift-add-3 step: correct every BCD digit >= 5, then shift in the next value bit.
    // The BCD register holds only N_DIGITS digits; any value below 10^N_DIGITS never needs more,
    // and for larger values the digits are discarded in favour of the overflow dashes.
    always_comb begin
        logic [BCD_W-1:0] adj;
        adj = bcd_q;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
    end

    // Capture on load and run the conversion, MSB first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh_q      <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            dp_cap_q  <= '0;
            ovf_cap_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        sh_q      <= bus.value;
                        bcd_q     <= '0;
                        bit_cnt_q <= '0;
                        dp_cap_q  <= bus.dp_sel;
                        ovf_cap_q <= (64'(bus.value) >= OVF_LIMIT);
                    end
                end
                CONVERT: begin
                    sh_q      <= sh_q << 1;
                    bcd_q     <= bcd_d;
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Atomic commit of digits, decimal points and overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_q <= '0;
            dp_q   <= '0;
            ovf_q  <= 1'b0;
        end else if (state_q == COMMIT) begin
            disp_q <= bcd_q;
            dp_q   <= ovf_cap_q ? '0 : dp_cap_q;
            ovf_q  <= ovf_cap_q;
        end
    end

    // Refresh divider and scan index, free-running regardless of conversion state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_q  <= '0;
            scan_idx_q <= '0;
        end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_q  <= '0;
            scan_idx_q <= (scan_idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end else begin
            refresh_q  <= refresh_q + CNT_W'(1);
        end
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        logic [3:0] cur_digit;
        logic       cur_dp;
`ifdef NUMERIC_DISPLAY_LZB_EN
        logic       nz_at_or_above;
`endif
        cur_digit = '0;
        cur_dp    = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == scan_idx_q) begin
                cur_digit = disp_q[4*i +: 4];
                cur_dp    = dp_q[i];
            end
        end
        if (ovf_q) begin
            seg_d = 8'hBF;
        end else begin
            seg_d = seg_of(cur_digit);
`ifdef NUMERIC_DISPLAY_LZB_EN
            nz_at_or_above = 1'b0;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                if (IDX_W'(i) >= scan_idx_q && disp_q[4*i +: 4] != 4'd0) begin
                    nz_at_or_above = 1'b1;
                end
            end
            if (scan_idx_q != '0 && !nz_at_or_above) begin
                seg_d = 8'hFF;
            end
`endif
            if (cur_dp) begin
                seg_d[7] = 1'b0;
            end
        end
        anode_d = ~(N_DIGITS'(1) << scan_idx_q);
    end

    // Registered display outputs, one cycle behind the scan index and display registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q   <= 8'hC0;
            anode_q <= ~(N_DIGITS'(1));
        end else begin
            seg_q   <= seg_d;
            anode_q <= anode_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.overflow = ovf_q;
    assign bus.seg_code = seg_q;
    assign bus.anode    = anode_q;

endmodule

// File: tb/tb_numeric_display_scanner.sv
// Self-checking bench for numeric_display_scanner (N_DIGITS=4, BIN_W=14, REFRESH_DIV=4).
// Expectations follow NUMERIC_DISPLAY_LZB_EN when it is defined for the build.
module tb_numeric_display_scanner;

    localparam int N  = 4;
    localparam int W  = 14;
    localparam int RD = 4;

`ifdef NUMERIC_DISPLAY_LZB_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif
    localparam logic [7:0] LZD = LZ & 8'h7F;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    numeric_display_scanner_if #(.N_DIGITS(N), .BIN_W(W)) bus ();

    numeric_display_scanner #(
        .N_DIGITS(N),
        .BIN_W(W),
        .REFRESH_DIV(RD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]      value;
        logic [N-1:0]      dp;
        logic              ovf;
        logic [N-1:0][7:0] seg;   // index = digit
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait until busy falls; returns the number of post-edge samples with busy high.
    task automatic wait_idle(output int high);
        high = 0;
        while (bus.busy === 1'b1 && high < 100) begin
            high++;
            tick();
        end
    endtask

    task automatic load_value(input logic [W-1:0] v, input logic [N-1:0] d, output int high);
        bus.value  = v;
        bus.dp_sel = d;
        bus.load   = 1'b1;
        tick();
        bus.load = 1'b0;
        wait_idle(high);
    endtask

    // Observe one full scan round and compare each sample with the digit its anode selects.
    task automatic check_display(input string name, input logic [N-1:0][7:0] exp, input logic ovf);
        int idx;
        tick();
        tick();
        chk({name, "_overflow"}, 32'(bus.overflow), 32'(ovf));
        for (int k = 0; k < 16; k++) begin
            case (bus.anode)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL %s_anode: got %b expected one-hot-low", name, bus.anode);
            end else begin
                chk($sformatf("%s_seg_d%0d", name, idx), 32'(bus.seg_code), 32'(exp[idx]));
            end
            tick();
        end
    endtask

    initial begin
        int high;
        logic [3:0] prev;
        logic found;
        logic [3:0] exp_an;

        vecs[0] = '{14'd1234,  4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{14'd42,    4'b0000, 1'b0, {LZ,    LZ,    8'h99, 8'hA4}};
        vecs[2] = '{14'd10000, 4'b0000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        vecs[3] = '{14'd5,     4'b0000, 1'b0, {LZ,    LZ,    LZ,    8'h92}};
        vecs[4] = '{14'd9999,  4'b1010, 1'b0, {8'h10, 8'h90, 8'h10, 8'h90}};
        vecs[5] = '{14'd0,     4'b0001, 1'b0, {LZ,    LZ,    LZ,    8'h40}};
        vecs[6] = '{14'd16383, 4'b1111, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        vecs[7] = '{14'd807,   4'b0100, 1'b0, {LZ,    8'h00, 8'hC0, 8'hF8}};
        vecs[8] = '{14'd42,    4'b1000, 1'b0, {LZD,   LZ,    8'h99, 8'hA4}};

        reset      = 1'b0;
        bus.load   = 1'b0;
        bus.value  = '0;
        bus.dp_sel = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_anode", 32'(bus.anode), 32'h0000_000E);
        chk("rst_seg", 32'(bus.seg_code), 32'h0000_00C0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ovf", 32'(bus.overflow), 32'h0);
        reset = 1'b1;

        // Free-running scan: sync on the 0111 -> 1110 wrap, then 4 cycles per digit
        found = 1'b0;
        prev  = bus.anode;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prev == 4'b0111 && bus.anode == 4'b1110) found = 1'b1;
            else prev = bus.anode;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL scan_sync: got no 0111->1110 wrap expected one within 40 cycles");
        end else begin
            for (int k = 0; k <= 16; k++) begin
                exp_an = ~(4'b0001 << ((k / 4) % 4));
                chk($sformatf("scan_anode_%0d", k), 32'(bus.anode), 32'(exp_an));
                tick();
            end
        end

        // Table of load/convert/display vectors
        for (int v = 0; v < 9; v++) begin
            load_value(vecs[v].value, vecs[v].dp, high);
            chk($sformatf("v%0d_busy_cycles", v), 32'(high), 32'd15);
            check_display($sformatf("v%0d", v), vecs[v].seg, vecs[v].ovf);
        end

        // load held through CONVERT with a different value must be ignored
        bus.value  = 14'd1234;
        bus.dp_sel = 4'b0000;
        bus.load   = 1'b1;
        tick();
        bus.value = 14'd7;
        for (int i = 0; i < 8; i++) tick();
        bus.load = 1'b0;
        wait_idle(high);
        chk("hold_busy_cycles", 32'(high), 32'd7);
        check_display("hold", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1'b0);

        // Reset in the fifth CONVERT cycle aborts the conversion and clears the display
        bus.value  = 14'd9999;
        bus.dp_sel = 4'b1111;
        bus.load   = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_busy_before", 32'(bus.busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_ovf", 32'(bus.overflow), 32'h0);
        chk("abort_anode", 32'(bus.anode), 32'h0000_000E);
        chk("abort_seg", 32'(bus.seg_code), 32'h0000_00C0);
        tick(); tick();
        reset = 1'b1;
        check_display("abort", {LZ, LZ, LZ, 8'hC0}, 1'b0);
        chk("abort_busy_after", 32'(bus.busy), 32'h0);

        // Asynchronous reset mid-scan while a non-zero digit is on a non-zero anode
        load_value(14'd1234, 4'b0000, high);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.anode == 4'b1011) found = 1'b1;
        end
        chk("midscan_found", 32'(found), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("midscan_anode", 32'(bus.anode), 32'h0000_000E);
        chk("midscan_seg", 32'(bus.seg_code), 32'h0000_00C0);
        chk("midscan_busy", 32'(bus.busy), 32'h0);
        chk("midscan_ovf", 32'(bus.overflow), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/numeric_display_scanner.md
NUMERIC_DISPLAY_SCANNER -- requirements
Module: numeric_display_scanner

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed 7-segment digits; legal range 1..8.
REQ-002 Parameter BIN_W, default 14, width of the binary input value; legal range 4..27.
REQ-003 Parameter REFRESH_DIV, default 50000, clock cycles each digit stays active; legal range >=2.
REQ-004 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port load  in  1  request to capture value/dp_sel; honoured only when busy=0.
REQ-007 Port value  in  BIN_W  unsigned binary number to display.
REQ-008 Port dp_sel  in  N_DIGITS  decimal-point enable per digit, bit i = digit i (digit 0 = least significant).
REQ-009 Port busy  out  1  high while a conversion is in progress.
REQ-010 Port overflow  out  1  high while the displayed value exceeds 10^N_DIGITS-1.
REQ-011 Port seg_code  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-012 Port anode  out  N_DIGITS  active-low one-hot digit enable.

Function
REQ-013 FSM states IDLE, CONVERT, COMMIT; busy SHALL be 1 in every state except IDLE.
REQ-014 IDLE: load=1 at an edge SHALL capture value and dp_sel and move to CONVERT; load is ignored in CONVERT and COMMIT.
REQ-015 CONVERT SHALL run shift-add-3 binary-to-BCD for exactly BIN_W cycles, one bit per cycle, MSB first, then go to COMMIT.
REQ-016 COMMIT (1 cycle) SHALL update all N_DIGITS display registers, dp registers and overflow atomically, then return to IDLE; load-to-busy-low latency is BIN_W+2 edges.
REQ-017 overflow SHALL be set when the captured value >= 10^N_DIGITS; then every digit SHALL show dash 0xBF with dp off.
REQ-018 Digit encoding 0..9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex, dp bit off); dp_sel bit set clears seg_code[7].
REQ-019 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the scan index SHALL advance, wrapping N_DIGITS-1 -> 0.
REQ-020 anode SHALL drive low only the bit of the scan index; seg_code SHALL carry that digit's pattern.
REQ-021 seg_code and anode SHALL be registered and SHALL reflect scan index and display registers of the previous cycle.
REQ-022 Scanning SHALL continue uninterrupted during CONVERT/COMMIT; old digits are shown until COMMIT.
REQ-023 N_DIGITS=1: anode is constant 0 (active) out of reset.

Reset
REQ-024 reset=0 SHALL immediately force: state IDLE, busy 0, overflow 0, display and dp registers 0, refresh counter 0, scan index 0.
REQ-025 During and after reset anode SHALL be all ones except bit 0 low, and seg_code SHALL be 0xC0.
REQ-026 reset asserted mid-CONVERT SHALL abort the conversion; the captured value is discarded.

Configuration
REQ-027 Macro NUMERIC_DISPLAY_LZB_EN: when defined, leading-zero blanking is compiled in; digits above the most significant non-zero digit show 0xFF (dp still honoured); digit 0 is never blanked.
REQ-028 When NUMERIC_DISPLAY_LZB_EN is undefined, all digits show their value including leading zeros; overflow dashes are unaffected.

Verification (N_DIGITS=4, BIN_W=14, REFRESH_DIV=4)
REQ-029 Assert reset=0 mid-scan -> anode=1110, seg_code=C0, busy=0, overflow=0 at once.
REQ-030 load value=1234, dp_sel=0000 -> busy high 15 edges; afterwards digit0..3 scan shows 99,B0,A4,F9.
REQ-031 load value=42 -> digits 2,3 show FF with LZB_EN defined, C0 without; digits 0,1 show A4,99.
REQ-032 load value=10000 -> overflow=1, all four digits BF; then load 5 -> overflow=0, digit0 92.
REQ-033 load held high during CONVERT with new value 7 -> ignored, display keeps first value; reset at CONVERT cycle 5 -> display 0, busy 0.
REQ-034 Free-run 16 cycles -> anode sequence 1110,1101,1011,0111, 4 cycles each, then 1110 again.
